// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative tag/status array.
package cache_pkg;

  // Status field bit positions: valid, dirty, user/reserved.
  localparam int ST_VALID   = 2;
  localparam int ST_DIRTY   = 1;
  localparam int ST_USER    = 0;
  localparam int STATUS_LEN = 3;

  // Controller states: clearing sweep, then normal operation.
  typedef enum logic {
    FSM_SWEEP = 1'b0,
    FSM_IDLE  = 1'b1
  } tag_fsm_t;

  // Width of a way-number field; a direct-mapped array still needs one bit.
  function automatic int way_w_of(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/cache_tag_bank.sv
// One way of tag/status storage: block RAM with a registered, read-first read
// port and an independent write port.
module cache_tag_bank #(
  parameter int INDEX_LEN = 10,
  parameter int DATA_LEN  = 16
) (
  input  logic                 clk,
  input  logic                 re,
  input  logic [INDEX_LEN-1:0] raddr,
  output logic [DATA_LEN-1:0]  rdata,
  input  logic                 we,
  input  logic [INDEX_LEN-1:0] waddr,
  input  logic [DATA_LEN-1:0]  wdata
);

  logic [DATA_LEN-1:0] mem_q [1<<INDEX_LEN];
  logic [DATA_LEN-1:0] rdata_q;

  // Read sees the old word when it collides with a write to the same address.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cache_tag_way_array.sv
// N-way tag/status array: self-clearing sweep, one-cycle lookup with hit
// detection and victim selection (first invalid way, else round-robin).
module cache_tag_way_array
  import cache_pkg::*;
#(
  parameter  int TAG_LEN   = 13,
  parameter  int INDEX_LEN = 10,
  parameter  int WAYS      = 2,
  localparam int WAY_W     = way_w_of(WAYS)
) (
  input  logic                  clk,
  input  logic                  rstn,
  output logic                  ready,
  input  logic                  flush_req,
  input  logic                  lk_req,
  input  logic [INDEX_LEN-1:0]  lk_index,
  input  logic [TAG_LEN-1:0]    lk_tag,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [WAY_W-1:0]      resp_way,
  output logic [STATUS_LEN-1:0] resp_status,
  output logic [WAY_W-1:0]      victim_way,
  output logic [TAG_LEN-1:0]    victim_tag,
  output logic [STATUS_LEN-1:0] victim_status,
  input  logic                  wr_en,
  input  logic [INDEX_LEN-1:0]  wr_index,
  input  logic [WAY_W-1:0]      wr_way,
  input  logic [TAG_LEN-1:0]    wr_tag,
  input  logic [STATUS_LEN-1:0] wr_status
);

  localparam int DEPTH     = 1 << INDEX_LEN;
  localparam int ENTRY_LEN = STATUS_LEN + TAG_LEN;
  localparam int VBIT      = TAG_LEN + ST_VALID;

  tag_fsm_t             state_q, state_d;
  logic [INDEX_LEN-1:0] sweep_cnt_q, sweep_cnt_d;
  logic                 ready_q, ready_d;

  logic sweeping, lk_acc, wr_acc;

  // FSM next state: sweep every set once, then serve until a flush.
  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    ready_d     = ready_q;
    case (state_q)
      FSM_SWEEP: begin
        sweep_cnt_d = sweep_cnt_q + 1'b1;
        if (sweep_cnt_q == {INDEX_LEN{1'b1}}) begin
          state_d = FSM_IDLE;
          ready_d = 1'b1;
        end
      end
      FSM_IDLE: begin
        if (flush_req) begin
          state_d     = FSM_SWEEP;
          sweep_cnt_d = '0;
          ready_d     = 1'b0;
        end
      end
      default: begin
        state_d     = FSM_SWEEP;
        sweep_cnt_d = '0;
        ready_d     = 1'b0;
      end
    endcase
  end

  // FSM registers; reset restarts the sweep from set 0.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= FSM_SWEEP;
      sweep_cnt_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      ready_q     <= ready_d;
    end
  end

  // A flush in the same cycle wins over any lookup or write.
  assign sweeping = (state_q == FSM_SWEEP);
  assign lk_acc   = ready_q & ~flush_req & lk_req;
  assign wr_acc   = ready_q & ~flush_req & wr_en;
  assign ready    = ready_q;

  logic [ENTRY_LEN-1:0] rd_data [WAYS];
  logic [INDEX_LEN-1:0] bank_waddr;
  logic [ENTRY_LEN-1:0] bank_wdata;

  assign bank_waddr = sweeping ? sweep_cnt_q : wr_index;
  assign bank_wdata = sweeping ? '0 : {wr_status, wr_tag};

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_tag_bank #(
      .INDEX_LEN (INDEX_LEN),
      .DATA_LEN  (ENTRY_LEN)
    ) u_bank (
      .clk   (clk),
      .re    (lk_acc),
      .raddr (lk_index),
      .rdata (rd_data[w]),
      .we    (sweeping | (wr_acc & (wr_way == WAY_W'(w)))),
      .waddr (bank_waddr),
      .wdata (bank_wdata)
    );
  end

  // Round-robin pointers live in registers, cleared by the sweep.
  logic [WAY_W-1:0]     rr_ptr_q [DEPTH];
  logic                 rr_we;
  logic [INDEX_LEN-1:0] rr_waddr;
  logic [WAY_W-1:0]     rr_wdata;

  // Pointer advances only when a valid fill lands on the way it points at.
  always_comb begin
    rr_we    = 1'b0;
    rr_waddr = wr_index;
    rr_wdata = '0;
    if (sweeping) begin
      rr_we    = 1'b1;
      rr_waddr = sweep_cnt_q;
    end else if (wr_acc && wr_status[ST_VALID] && (wr_way == rr_ptr_q[wr_index])) begin
      rr_we    = 1'b1;
      rr_wdata = (WAYS == 1) ? '0 : rr_ptr_q[wr_index] + 1'b1;
    end
  end

  // Pointer array write port.
  always_ff @(posedge clk) begin
    if (rr_we) rr_ptr_q[rr_waddr] <= rr_wdata;
  end

  logic                 resp_valid_q, resp_valid_d;
  logic [TAG_LEN-1:0]   lk_tag_q, lk_tag_d;
  logic [WAY_W-1:0]     rr_rd_q, rr_rd_d;

  // Capture the compare tag and the pointer alongside the RAM read so a
  // same-cycle write cannot leak into this response.
  always_comb begin
    resp_valid_d = lk_acc;
    lk_tag_d     = lk_acc ? lk_tag : lk_tag_q;
    rr_rd_d      = lk_acc ? rr_ptr_q[lk_index] : rr_rd_q;
  end

  // Response-stage registers; only the valid flag is reset.
  always_ff @(posedge clk) begin
    if (!rstn) resp_valid_q <= 1'b0;
    else       resp_valid_q <= resp_valid_d;
    lk_tag_q <= lk_tag_d;
    rr_rd_q  <= rr_rd_d;
  end

  logic                  hit;
  logic [WAY_W-1:0]      hit_way, inv_way, vict_way;
  logic [STATUS_LEN-1:0] hit_st;
  logic                  inv_found;
  logic [ENTRY_LEN-1:0]  vict_entry;

  // Hit/victim decode; scanning downward lets the lowest way win.
  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    hit_st     = '0;
    inv_found  = 1'b0;
    inv_way    = '0;
    vict_entry = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (rd_data[w][VBIT] && (rd_data[w][TAG_LEN-1:0] == lk_tag_q)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
        hit_st  = rd_data[w][ENTRY_LEN-1 -: STATUS_LEN];
      end
      if (!rd_data[w][VBIT]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    vict_way = inv_found ? inv_way : rr_rd_q;
    if (WAYS == 1) vict_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (vict_way == WAY_W'(w)) vict_entry = rd_data[w];
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_hit      = resp_valid_q & hit;
  assign resp_way      = resp_valid_q ? hit_way : '0;
  assign resp_status   = resp_valid_q ? hit_st : '0;
  assign victim_way    = resp_valid_q ? vict_way : '0;
  assign victim_tag    = resp_valid_q ? vict_entry[TAG_LEN-1:0] : '0;
  assign victim_status = resp_valid_q ? vict_entry[ENTRY_LEN-1 -: STATUS_LEN] : '0;

endmodule

// File: tb/tb_cache_tag_way_array.sv
// Directed plus randomized bench for cache_tag_way_array with a set/way
// array reference model.
module tb_cache_tag_way_array;

  localparam int TAG_LEN   = 13;
  localparam int INDEX_LEN = 10;
  localparam int WAYS      = 2;
  localparam int WAY_W     = 1;
  localparam int DEPTH     = 1 << INDEX_LEN;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 ready;
  logic                 flush_req = 1'b0;
  logic                 lk_req = 1'b0;
  logic [INDEX_LEN-1:0] lk_index = '0;
  logic [TAG_LEN-1:0]   lk_tag = '0;
  logic                 resp_valid, resp_hit;
  logic [WAY_W-1:0]     resp_way, victim_way;
  logic [2:0]           resp_status, victim_status;
  logic [TAG_LEN-1:0]   victim_tag;
  logic                 wr_en = 1'b0;
  logic [INDEX_LEN-1:0] wr_index = '0;
  logic [WAY_W-1:0]     wr_way = '0;
  logic [TAG_LEN-1:0]   wr_tag = '0;
  logic [2:0]           wr_status = '0;

  always #5 clk = ~clk;

  cache_tag_way_array #(.TAG_LEN(TAG_LEN), .INDEX_LEN(INDEX_LEN), .WAYS(WAYS)) dut (
    .clk(clk), .rstn(rstn), .ready(ready), .flush_req(flush_req),
    .lk_req(lk_req), .lk_index(lk_index), .lk_tag(lk_tag),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .resp_status(resp_status), .victim_way(victim_way), .victim_tag(victim_tag),
    .victim_status(victim_status), .wr_en(wr_en), .wr_index(wr_index),
    .wr_way(wr_way), .wr_tag(wr_tag), .wr_status(wr_status)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: contents per way per set, replacement pointer per set.
  int  m_tag [WAYS][DEPTH];
  int  m_st  [WAYS][DEPTH];
  int  m_ptr [DEPTH];
  bit  m_rdy = 0;

  task automatic chk(input string name, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_ptr[i] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_tag[w][i] = 0;
        m_st[w][i]  = 0;
      end
    end
  endtask

  // Expected lookup response from the model's current contents.
  task automatic model_lookup(input int idx, input int tag,
                              output int h, output int hw, output int hs,
                              output int vw, output int vt, output int vs);
    h = 0; hw = 0; hs = 0; vw = -1;
    for (int w = 0; w < WAYS; w++) begin
      if (h == 0 && (m_st[w][idx] & 4) != 0 && m_tag[w][idx] == tag) begin
        h = 1; hw = w; hs = m_st[w][idx];
      end
      if (vw < 0 && (m_st[w][idx] & 4) == 0) vw = w;
    end
    if (vw < 0) vw = m_ptr[idx];
    vt = m_tag[vw][idx];
    vs = m_st[vw][idx];
  endtask

  // One clock of stimulus; checks the response that appears after the edge.
  task automatic step(input bit lk, input int li, input int lt,
                      input bit we, input int wi, input int ww, input int wt, input int ws,
                      input bit fl);
    int ev, h, hw, hs, vw, vt, vs;
    ev = (lk && m_rdy && !fl) ? 1 : 0;
    if (ev) model_lookup(li, lt, h, hw, hs, vw, vt, vs);
    lk_req = lk; lk_index = INDEX_LEN'(li); lk_tag = TAG_LEN'(lt);
    wr_en = we; wr_index = INDEX_LEN'(wi); wr_way = WAY_W'(ww);
    wr_tag = TAG_LEN'(wt); wr_status = 3'(ws);
    flush_req = fl;
    @(posedge clk);
    #1;
    lk_req = 0; wr_en = 0; flush_req = 0;
    chk("resp_valid", int'(resp_valid), ev);
    if (ev) begin
      chk("resp_hit", int'(resp_hit), h);
      chk("resp_way", int'(resp_way), hw);
      chk("resp_status", int'(resp_status), hs);
      chk("victim_way", int'(victim_way), vw);
      chk("victim_tag", int'(victim_tag), vt);
      chk("victim_status", int'(victim_status), vs);
    end
    if (m_rdy && fl) begin
      model_clear();
      m_rdy = 0;
    end else if (m_rdy && we) begin
      if ((ws & 4) != 0 && ww == m_ptr[wi]) m_ptr[wi] = (m_ptr[wi] + 1) % WAYS;
      m_tag[ww][wi] = wt;
      m_st[ww][wi]  = ws;
    end
  endtask

  task automatic lookup(input int li, input int lt);
    step(1, li, lt, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic write(input int wi, input int ww, input int wt, input int ws);
    step(0, 0, 0, 1, wi, ww, wt, ws, 0);
  endtask

  // Count samples with ready low, bounded.
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 3000) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk(name, n, DEPTH);
    model_clear();
    m_rdy = 1;
  endtask

  initial begin
    int li, lt, ww;
    bit lk, we;

    // Reset state
    rstn = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", int'(ready), 0);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_resp_hit", int'(resp_hit), 0);
    chk("rst_victim_way", int'(victim_way), 0);
    chk("rst_victim_tag", int'(victim_tag), 0);
    rstn = 1;
    wait_ready("init_sweep_len");

    // Cleared array: everything misses, victim is way 0 and invalid
    lookup(123, 0);
    chk("clear_victim_status", int'(victim_status), 0);
    lookup(1023, 7);

    // Miss, fill, hit
    lookup(5, 'h1A3);
    chk("mfh_miss", int'(resp_hit), 0);
    write(5, 0, 'h1A3, 3'b100);
    lookup(5, 'h1A3);
    chk("mfh_hit", int'(resp_hit), 1);
    chk("mfh_status", int'(resp_status), 3'b100);
    chk("mfh_victim", int'(victim_way), 1);

    // Round-robin replacement
    write(7, 0, 'h10, 3'b100);
    write(7, 1, 'h20, 3'b100);
    lookup(7, 'h30);
    chk("rr_victim0", int'(victim_way), 0);
    chk("rr_victim_tag", int'(victim_tag), 'h10);
    write(7, 0, 'h40, 3'b110);
    lookup(7, 'h30);
    chk("rr_victim1", int'(victim_way), 1);

    // Same-cycle lookup and write: read-first
    step(1, 9, 'h55, 1, 9, 0, 'h55, 3'b110, 0);
    chk("coll_old", int'(resp_hit), 0);
    lookup(9, 'h55);
    chk("coll_new", int'(resp_hit), 1);
    chk("coll_status", int'(resp_status), 3'b110);

    // Randomized traffic on a few sets with a small tag space
    for (int i = 0; i < 400; i++) begin
      lk = ($urandom_range(0, 9) < 7);
      we = ($urandom_range(0, 1) == 1);
      li = 32 + $urandom_range(0, 5);
      lt = $urandom_range(0, 3);
      ww = ($urandom_range(0, 1) == 1) ? m_ptr[li] : $urandom_range(0, WAYS - 1);
      step(lk, li, lt, we, ($urandom_range(0, 1) == 1) ? li : 32 + $urandom_range(0, 5),
           ww, $urandom_range(0, 3), $urandom_range(0, 7), 0);
    end

    // Flush beats a same-cycle lookup, then everything misses
    step(1, 5, 'h1A3, 0, 0, 0, 0, 0, 1);
    wait_ready("flush_sweep_len");
    lookup(5, 'h1A3);
    chk("flush_miss5", int'(resp_hit), 0);
    lookup(7, 'h40);
    chk("flush_miss7", int'(resp_hit), 0);

    // Reset in the middle of a sweep; lookups and writes during the sweep are ignored
    write(5, 0, 'h1A3, 3'b100);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 499; i++) step(1, 5, 'h1A3, 1, 5, 0, 'h1A3, 3'b100, 0);
    rstn = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_ready", int'(ready), 0);
    rstn = 1;
    wait_ready("midrst_sweep_len");
    lookup(5, 'h1A3);
    chk("midrst_miss", int'(resp_hit), 0);
    lookup(5, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
